reset_sequencer: RTL and testbench

Parametrised successor to the single-counter reset delay used at board top level. It generates `NUM_CH` independent active-low reset outputs and releases them in ascending channel order, one every `STEP` clock cycles, after a synchronized power-on or key reset. It also supports PLL-lock gating, a software-requested ordered shutdown with automatic restart, and a one-cycle release pulse per channel. It sits in `DE0_NANO` between the key/PLL inputs and the SDRAM controller, MTL IP, Nios system and SPI bridge resets.

---
 rtl/reset_sequencer_pkg.sv | 14 +
 rtl/bit_sync.sv | 29 ++
 rtl/reset_sequencer.sv | 147 ++++++++++++++
 tb/tb_reset_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the ordered reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {ASSERT, COUNT, DONE, SHUTDOWN} rst_seq_state_t;

  // Counter width able to hold the terminal release count num_ch*step-1
  // without ever wrapping.
  function automatic int cnt_width(input int num_ch, input int step);
    return $clog2(num_ch * step + 1);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop single-bit synchronizer with asynchronous clear to RST_VAL.
// Latency: STAGES cycles from d to q.
// Backpressure: none; level signal, always accepted.
//
// Ports: iCLK clock, iRSTN async active-low clear, d async input,
//        q synchronized output.
module bit_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic iCLK,
  input  logic iRSTN,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      sr <= {STAGES{RST_VAL}};
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Ordered multi-channel reset release/shutdown with PLL-lock gating.
// Latency: COUNT entered SYNC_STAGES+1 edges after iRSTN rises; channel k
//          released (k+1)*STEP edges later. Backpressure: none, all outputs
//          registered; iSW_RST is a pulse, ignored in ASSERT and SHUTDOWN.
//
// Ports: iCLK, iRSTN (async active-low), iLOCKED (async PLL lock),
//        iSW_RST (sync pulse), oRSTN[NUM_CH] per-channel resets,
//        oREL[NUM_CH] release pulses, oDONE all released, oBUSY counting
//        or shutting down.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int STEP        = 2**20,
  parameter int SHUT_GAP    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              iCLK,
  input  logic              iRSTN,
  input  logic              iLOCKED,
  input  logic              iSW_RST,
  output logic [NUM_CH-1:0] oRSTN,
  output logic [NUM_CH-1:0] oREL,
  output logic              oDONE,
  output logic              oBUSY
);

  // The counter is reused as the shutdown gap timer, so it must also hold
  // SHUT_GAP-1 in the unusual case that SHUT_GAP exceeds the release span.
  localparam int CW_SEQ  = cnt_width(NUM_CH, STEP);
  localparam int CW_SHUT = cnt_width(1, SHUT_GAP);
  localparam int CW      = (CW_SEQ > CW_SHUT) ? CW_SEQ : CW_SHUT;

  localparam logic [CW-1:0] CNT_LAST    = CW'(NUM_CH * STEP - 1);
  localparam logic [CW-1:0] SHUT_RELOAD = CW'(SHUT_GAP - 1);

  logic           rst_s;
  logic           lock_s;
  logic [CW-1:0]  cnt;
  rst_seq_state_t state;
  logic [NUM_CH-1:0] rel_hit;

  bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_rst_sync (
    .iCLK  (iCLK),
    .iRSTN (iRSTN),
    .d     (1'b1),
    .q     (rst_s)
  );

  bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_lock_sync (
    .iCLK  (iCLK),
    .iRSTN (iRSTN),
    .d     (iLOCKED),
    .q     (lock_s)
  );

  // One-hot (at most) match of the counter against each channel's release
  // point; release points are distinct because STEP >= 2.
  always_comb begin
    rel_hit = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      rel_hit[k] = (cnt == CW'((k + 1) * STEP - 1));
    end
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state <= ASSERT;
      cnt   <= '0;
      oRSTN <= '0;
      oREL  <= '0;
      oDONE <= 1'b0;
      oBUSY <= 1'b0;
    end else begin
      oREL <= '0;
      if (state != ASSERT && !lock_s) begin
        // Lock loss wins over any software request.
        state <= ASSERT;
        cnt   <= '0;
        oRSTN <= '0;
        oDONE <= 1'b0;
        oBUSY <= 1'b0;
      end else begin
        case (state)
          ASSERT: begin
            cnt   <= '0;
            oRSTN <= '0;
            oDONE <= 1'b0;
            if (rst_s && lock_s) begin
              state <= COUNT;
              oBUSY <= 1'b1;
            end else begin
              oBUSY <= 1'b0;
            end
          end
          COUNT: begin
            if (iSW_RST) begin
              state <= ASSERT;
              cnt   <= '0;
              oRSTN <= '0;
              oBUSY <= 1'b0;
            end else begin
              oRSTN <= oRSTN | rel_hit;
              oREL  <= rel_hit;
              if (cnt == CNT_LAST) begin
                state <= DONE;
                oDONE <= 1'b1;
                oBUSY <= 1'b0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          DONE: begin
            if (iSW_RST) begin
              state <= SHUTDOWN;
              cnt   <= '0;
              oBUSY <= 1'b1;
            end
          end
          SHUTDOWN: begin
            oDONE <= 1'b0;
            // Released channels are a contiguous low prefix, so dropping the
            // highest released channel is a right shift; cnt counts down the gap.
            if (oRSTN == '0) begin
              state <= ASSERT;
              oBUSY <= 1'b0;
            end else if (cnt == '0) begin
              oRSTN <= oRSTN >> 1;
              cnt   <= SHUT_RELOAD;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            state <= ASSERT;
            cnt   <= '0;
            oRSTN <= '0;
            oDONE <= 1'b0;
            oBUSY <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer (NUM_CH=3, STEP=8,
// SHUT_GAP=4, SYNC_STAGES=2).
// Outputs are sampled 1 time unit after each rising edge.
module tb_reset_sequencer;
  import reset_sequencer_pkg::*;

  logic       iCLK;
  logic       iRSTN;
  logic       iLOCKED;
  logic       iSW_RST;
  logic [2:0] oRSTN;
  logic [2:0] oREL;
  logic       oDONE;
  logic       oBUSY;

  int checks   = 0;
  int failures = 0;

  reset_sequencer #(
    .NUM_CH      (3),
    .STEP        (8),
    .SHUT_GAP    (4),
    .SYNC_STAGES (2)
  ) dut (
    .iCLK    (iCLK),
    .iRSTN   (iRSTN),
    .iLOCKED (iLOCKED),
    .iSW_RST (iSW_RST),
    .oRSTN   (oRSTN),
    .oREL    (oREL),
    .oDONE   (oDONE),
    .oBUSY   (oBUSY)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // Hand-derived release schedule, rel = edges since COUNT entry (E0).
  function automatic logic [31:0] exp_rstn(input int rel);
    if (rel >= 24) return 32'd7;
    if (rel >= 16) return 32'd3;
    if (rel >= 8)  return 32'd1;
    return 32'd0;
  endfunction

  function automatic logic [31:0] exp_rel(input int rel);
    if (rel == 8)  return 32'd1;
    if (rel == 16) return 32'd2;
    if (rel == 24) return 32'd4;
    return 32'd0;
  endfunction

  // Step n_edges edges; COUNT is expected to be entered on edge e0.
  task automatic follow(input string tag, input int e0, input int n_edges);
    for (int n = 1; n <= n_edges; n++) begin
      int rel;
      tick();
      rel = n - e0;
      check_eq($sformatf("%s e%0d rstn", tag, n), 32'(oRSTN), exp_rstn(rel));
      check_eq($sformatf("%s e%0d rel", tag, n), 32'(oREL), exp_rel(rel));
      check_eq($sformatf("%s e%0d done", tag, n), 32'(oDONE), (rel >= 24) ? 32'd1 : 32'd0);
      check_eq($sformatf("%s e%0d busy", tag, n), 32'(oBUSY),
               (rel >= 0 && rel < 24) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic pulse_sw();
    iSW_RST = 1'b1;
    tick();
    iSW_RST = 1'b0;
  endtask

  initial begin
    iRSTN   = 1'b0;
    iLOCKED = 1'b1;
    iSW_RST = 1'b0;

    // Reset state
    tick();
    tick();
    check_eq("rst rstn", 32'(oRSTN), 32'd0);
    check_eq("rst rel", 32'(oREL), 32'd0);
    check_eq("rst done", 32'(oDONE), 32'd0);
    check_eq("rst busy", 32'(oBUSY), 32'd0);
    check_eq("rst state", 32'(dut.state), 32'(ASSERT));

    // Power-up, interrupted by an async reset between edges 14 and 15
    iRSTN = 1'b1;
    follow("pwr", 3, 14);
    #4;
    iRSTN = 1'b0;
    #1;
    check_eq("arst rstn", 32'(oRSTN), 32'd0);
    check_eq("arst rel", 32'(oREL), 32'd0);
    check_eq("arst done", 32'(oDONE), 32'd0);
    check_eq("arst busy", 32'(oBUSY), 32'd0);
    #1;
    iRSTN = 1'b1;
    follow("pwr2", 3, 30);

    // Ordered shutdown from DONE
    pulse_sw();
    check_eq("shd entry rstn", 32'(oRSTN), 32'd7);
    check_eq("shd entry done", 32'(oDONE), 32'd1);
    check_eq("shd entry busy", 32'(oBUSY), 32'd1);
    for (int s = 1; s <= 10; s++) begin
      tick();
      check_eq($sformatf("shd s%0d rstn", s), 32'(oRSTN),
               (s < 5) ? 32'd3 : (s < 9) ? 32'd1 : 32'd0);
      check_eq($sformatf("shd s%0d done", s), 32'(oDONE), 32'd0);
      check_eq($sformatf("shd s%0d busy", s), 32'(oBUSY), (s < 10) ? 32'd1 : 32'd0);
    end
    check_eq("shd end state", 32'(dut.state), 32'(ASSERT));
    follow("rstrt", 1, 12);

    // Software reset mid-COUNT with oRSTN=001
    check_eq("sw pre rstn", 32'(oRSTN), 32'd1);
    pulse_sw();
    check_eq("sw rstn", 32'(oRSTN), 32'd0);
    check_eq("sw busy", 32'(oBUSY), 32'd0);
    check_eq("sw state", 32'(dut.state), 32'(ASSERT));
    follow("swrst", 1, 26);

    // Lock loss during shutdown
    pulse_sw();
    tick();
    tick();
    tick();
    check_eq("ll s3 rstn", 32'(oRSTN), 32'd3);
    iLOCKED = 1'b0;
    tick();
    check_eq("ll l1 rstn", 32'(oRSTN), 32'd3);
    tick();
    check_eq("ll l2 rstn", 32'(oRSTN), 32'd1);
    tick();
    check_eq("ll l3 rstn", 32'(oRSTN), 32'd0);
    check_eq("ll l3 done", 32'(oDONE), 32'd0);
    check_eq("ll l3 busy", 32'(oBUSY), 32'd0);
    for (int n = 0; n < 20; n++) begin
      tick();
      check_eq($sformatf("ll hold%0d rstn", n), 32'(oRSTN), 32'd0);
      check_eq($sformatf("ll hold%0d busy", n), 32'(oBUSY), 32'd0);
    end
    iLOCKED = 1'b1;
    follow("relock", 3, 30);

    // Lock held low for 40 cycles after reset release
    iRSTN   = 1'b0;
    iLOCKED = 1'b0;
    tick();
    tick();
    iRSTN = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      check_eq($sformatf("lk e%0d rstn", n), 32'(oRSTN), 32'd0);
      check_eq($sformatf("lk e%0d busy", n), 32'(oBUSY), 32'd0);
    end
    iLOCKED = 1'b1;
    follow("lkrise", 3, 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
